// File: rtl/port_page_list_if.sv
// Request/response bundle between the port-level client, the page list
// manager and the SRAM state tracker. The slave side is the list manager.
interface port_page_list_if #(
  parameter int PORT_NUM        = 16,
  parameter int PAGE_ADDR_WIDTH = 11
);
  localparam int PW = $clog2(PORT_NUM);

  logic                       wr_req;
  logic [PW-1:0]              wr_req_port;
  logic                       wr_ready;
  logic                       rd_req;
  logic [PW-1:0]              rd_req_port;
  logic                       rd_ready;
  logic                       rd_err;
  logic [PAGE_ADDR_WIDTH-1:0] null_ptr;
  logic [PAGE_ADDR_WIDTH-1:0] free_space;
  logic                       wr_op;
  logic [PW-1:0]              wr_port;
  logic [PAGE_ADDR_WIDTH-1:0] wr_page;
  logic                       rd_op;
  logic [PW-1:0]              rd_port;
  logic [PAGE_ADDR_WIDTH-1:0] rd_addr;
  logic [PORT_NUM-1:0]        port_empty;

  modport master (
    output wr_req, wr_req_port, rd_req, rd_req_port, null_ptr, free_space,
    input  wr_ready, rd_ready, rd_err, wr_op, wr_port, wr_page,
           rd_op, rd_port, rd_addr, port_empty
  );

  modport slave (
    input  wr_req, wr_req_port, rd_req, rd_req_port, null_ptr, free_space,
    output wr_ready, rd_ready, rd_err, wr_op, wr_port, wr_page,
           rd_op, rd_port, rd_addr, port_empty
  );
endinterface

// File: rtl/port_page_list.sv
// Per-port linked-list page manager. Writes append the tracker's null_ptr
// to a port queue in the same cycle; pops release the oldest page of a port
// through a two-state read FSM.
//
// state | meaning
// IDLE  | ready for a pop request; head of the requested port is sent to the
//       | next-pointer table read port
// POP   | rd_op is out for the latched port; head advances to the table data
module port_page_list #(
  parameter int PORT_NUM        = 16,
  parameter int PAGE_ADDR_WIDTH = 11,
  parameter int PAGE_DEPTH      = 2048
) (
  input logic              clk,
  input logic              rst,
  port_page_list_if.slave  bus
);
  localparam int PW = $clog2(PORT_NUM);
  localparam int AW = PAGE_ADDR_WIDTH;

  typedef enum logic {IDLE = 1'b0, POP = 1'b1} state_t;

  state_t state, state_next;

  logic [AW-1:0] cnt       [PORT_NUM];
  logic [AW-1:0] head      [PORT_NUM];
  logic [AW-1:0] tail      [PORT_NUM];
  logic [AW-1:0] cnt_next  [PORT_NUM];
  logic [AW-1:0] head_next [PORT_NUM];
  logic [AW-1:0] tail_next [PORT_NUM];

  logic [AW-1:0] next_tbl [PAGE_DEPTH];
  logic [AW-1:0] tbl_rd_data;
  logic [AW-1:0] tbl_rd_addr;
  logic [AW-1:0] tbl_wr_addr;
  logic          tbl_wr_en;

  logic          wr_ready;
  logic          wr_accept;
  logic          pop_accept;
  logic          pop_empty;
  logic          rd_ready;
  logic          last_page_refill;

  logic          rd_op_q;
  logic          rd_err_q;
  logic [PW-1:0] rd_port_q;
  logic [AW-1:0] rd_addr_q;
  logic [PORT_NUM-1:0] port_empty_q;

  assign wr_ready  = (bus.free_space != '0);
  assign wr_accept = bus.wr_req && wr_ready;

  assign bus.wr_ready   = wr_ready;
  assign bus.wr_op      = wr_accept;
  assign bus.wr_port    = bus.wr_req_port;
  assign bus.wr_page    = bus.null_ptr;
  assign bus.rd_ready   = rd_ready;
  assign bus.rd_err     = rd_err_q;
  assign bus.rd_port    = rd_port_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.port_empty = port_empty_q;
  // The tracker resets on the same edge, so a release pending during reset is dropped.
  assign bus.rd_op      = rd_op_q && !rst;

  // Append goes behind the current tail unless the port is empty.
  assign tbl_wr_en   = wr_accept && (cnt[bus.wr_req_port] != '0);
  assign tbl_wr_addr = tail[bus.wr_req_port];
  assign tbl_rd_addr = head[bus.rd_req_port];

  // Writing into a port whose only page is leaving this cycle restarts the list.
  assign last_page_refill = (state == POP) && (rd_port_q == bus.wr_req_port) &&
                            (cnt[rd_port_q] == AW'(1));

  // Read FSM: accept pops in IDLE, flag pops on empty ports.
  always_comb begin
    state_next = state;
    rd_ready   = 1'b0;
    pop_accept = 1'b0;
    pop_empty  = 1'b0;
    case (state)
      IDLE: begin
        rd_ready = 1'b1;
        if (bus.rd_req) begin
          if (cnt[bus.rd_req_port] != '0) begin
            pop_accept = 1'b1;
            state_next = POP;
          end else begin
            pop_empty = 1'b1;
          end
        end
      end
      POP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next head/tail/count per port from the pop in flight and the write.
  always_comb begin
    cnt_next  = cnt;
    head_next = head;
    tail_next = tail;
    if (state == POP) begin
      cnt_next[rd_port_q]  = cnt[rd_port_q] - 1'b1;
      head_next[rd_port_q] = tbl_rd_data;
    end
    if (wr_accept) begin
      cnt_next[bus.wr_req_port]  = cnt_next[bus.wr_req_port] + 1'b1;
      tail_next[bus.wr_req_port] = bus.null_ptr;
      if ((cnt[bus.wr_req_port] == '0) || last_page_refill) begin
        head_next[bus.wr_req_port] = bus.null_ptr;
      end
    end
  end

  // Next-pointer table write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (tbl_wr_en) begin
      next_tbl[tbl_wr_addr] <= bus.null_ptr;
    end
  end

  // Synchronous table read with write-first bypass on an address collision.
  always_ff @(posedge clk) begin
    if (tbl_wr_en && (tbl_wr_addr == tbl_rd_addr)) begin
      tbl_rd_data <= bus.null_ptr;
    end else begin
      tbl_rd_data <= next_tbl[tbl_rd_addr];
    end
  end

  // State, list registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '{default: '0};
      head         <= '{default: '0};
      tail         <= '{default: '0};
      port_empty_q <= '1;
      rd_op_q      <= 1'b0;
      rd_err_q     <= 1'b0;
      rd_port_q    <= '0;
      rd_addr_q    <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      head     <= head_next;
      tail     <= tail_next;
      rd_op_q  <= pop_accept;
      rd_err_q <= pop_empty;
      for (int i = 0; i < PORT_NUM; i++) begin
        port_empty_q[i] <= (cnt_next[i] == '0);
      end
      if (pop_accept) begin
        rd_port_q <= bus.rd_req_port;
        rd_addr_q <= head[bus.rd_req_port];
      end
    end
  end
endmodule
